nop_meta_decoder: RTL and testbench

Decode-stage consumer of the NOP metadata lane produced by the fetch-side NOP detector. Accepts 10-bit metadata beats, buffers them in a small FIFO, and unpacks each entry into a protection window: a 4-bit region ID held active for a programmed number of decode cycles. Downstream AVF/fault-tolerance logic reads the window outputs to enable cross-layer protection on the tagged region.

---
 rtl/nop_meta_pkg.sv | 11 +
 rtl/nop_meta_fifo.sv | 41 ++++
 rtl/nop_meta_decoder.sv | 88 ++++++++
 tb/tb_nop_meta_decoder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/nop_meta_pkg.sv
// nop_meta_pkg: shared widths, metadata beat layout and window FSM states for the NOP metadata decoder.
package nop_meta_pkg;
  localparam int META_W   = 10;
  localparam int REGION_W = 4;
  localparam int COUNT_W  = 6;
  typedef struct packed {
    logic [REGION_W-1:0] region;
    logic [COUNT_W-1:0]  count;
  } nop_meta_t;
  typedef enum logic {IDLE, ACTIVE} state_e;
endpackage

// File: rtl/nop_meta_fifo.sv
// nop_meta_fifo: DEPTH-entry synchronous FIFO with flush; ports clk, reset (async high), flush, push, pop, wdata, rdata (head), full, empty.
module nop_meta_fifo import nop_meta_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = META_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end
  assign rdata = mem_q[rptr_q];
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/nop_meta_decoder.sv
// nop_meta_decoder: buffers NOP metadata beats and opens a protection window (region, cycle count) per entry.
// Ports: clk, reset (async high), stall_decode, flush, meta_valid, meta[META_W-1:0] in;
//        win_active, win_region[3:0], win_remaining[5:0], fifo_full, fifo_empty, drop_pulse out;
//        drop_count[7:0] out only when NOP_META_DROP_CNT_EN is defined.
module nop_meta_decoder #(
  parameter int DEPTH  = 4,
  parameter int META_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_decode,
  input  logic              flush,
  input  logic              meta_valid,
  input  logic [META_W-1:0] meta,
  output logic              win_active,
  output logic [3:0]        win_region,
  output logic [5:0]        win_remaining,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              drop_pulse
`ifdef NOP_META_DROP_CNT_EN
  , output logic [7:0]      drop_count
`endif
);
  import nop_meta_pkg::*;
  state_e      state_q, state_d;
  logic [3:0]  region_q, region_d;
  logic [5:0]  rem_q, rem_d;
  logic        drop_q;
  logic        full, empty, fire, pop, push, drop;
  logic [META_W-1:0] head_raw;
  nop_meta_t   head;
  nop_meta_fifo #(.DEPTH(DEPTH), .W(META_W)) u_fifo (
    .clk(clk), .reset(reset), .flush(flush), .push(push), .pop(pop),
    .wdata(meta), .rdata(head_raw), .full(full), .empty(empty)
  );
  assign head = head_raw;
  assign fire = meta_valid && !stall_decode && !flush;
  // Pop when idle, or on the last window cycle so the next window follows without a gap.
  assign pop  = !flush && !empty && (state_q == IDLE || (!stall_decode && rem_q == 6'd1));
  assign push = fire && (!full || pop);
  assign drop = fire && full && !pop;
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    rem_d    = rem_q;
    if (flush) begin
      state_d  = IDLE;
      region_d = '0;
      rem_d    = '0;
    end else if (pop) begin
      state_d  = head.count != '0 ? ACTIVE : IDLE;
      region_d = head.count != '0 ? head.region : '0;
      rem_d    = head.count;
    end else if (state_q == ACTIVE && !stall_decode) begin
      rem_d    = rem_q - 6'd1;
      state_d  = rem_q == 6'd1 ? IDLE : ACTIVE;
      region_d = rem_q == 6'd1 ? '0 : region_q;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      region_q <= '0;
      rem_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      rem_q    <= rem_d;
      drop_q   <= drop;
    end
  end
`ifdef NOP_META_DROP_CNT_EN
  logic [7:0] dcnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dcnt_q <= '0;
    else if (drop && dcnt_q != 8'hFF) dcnt_q <= dcnt_q + 8'd1;
  end
  assign drop_count = dcnt_q;
`endif
  assign win_active    = state_q == ACTIVE;
  assign win_region    = region_q;
  assign win_remaining = rem_q;
  assign fifo_full     = full;
  assign fifo_empty    = empty;
  assign drop_pulse    = drop_q;
endmodule

// File: tb/tb_nop_meta_decoder.sv
// tb_nop_meta_decoder: scoreboard bench; stimulus queues expected post-edge outputs, monitor compares after each edge.
module tb_nop_meta_decoder;
  logic       clk = 1'b0, reset = 1'b1, stall_decode = 1'b0, flush = 1'b0, meta_valid = 1'b0;
  logic [9:0] meta = '0;
  logic       win_active, fifo_full, fifo_empty, drop_pulse;
  logic [3:0] win_region;
  logic [5:0] win_remaining;
`ifdef NOP_META_DROP_CNT_EN
  logic [7:0] drop_count;
`endif
  int total = 0, bad = 0, vec = 0;
  typedef struct {
    logic       a;
    logic [3:0] r;
    logic [5:0] rem;
    logic       f;
    logic       e;
    logic       d;
  } exp_t;
  exp_t q[$];

  nop_meta_decoder #(.DEPTH(4), .META_W(10)) dut (
    .clk(clk), .reset(reset), .stall_decode(stall_decode), .flush(flush),
    .meta_valid(meta_valid), .meta(meta), .win_active(win_active),
    .win_region(win_region), .win_remaining(win_remaining),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .drop_pulse(drop_pulse)
`ifdef NOP_META_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".active"}, 32'(win_active), 0);
    check({tag, ".region"}, 32'(win_region), 0);
    check({tag, ".remaining"}, 32'(win_remaining), 0);
    check({tag, ".full"}, 32'(fifo_full), 0);
    check({tag, ".empty"}, 32'(fifo_empty), 1);
    check({tag, ".drop"}, 32'(drop_pulse), 0);
`ifdef NOP_META_DROP_CNT_EN
    check({tag, ".drop_count"}, 32'(drop_count), 0);
`endif
  endtask

  // One cycle of stimulus plus the outputs expected right after the following edge.
  task automatic cyc(input logic v, input logic [9:0] m, input logic s, input logic f,
                     input logic a, input logic [3:0] r, input logic [5:0] rem,
                     input logic fu, input logic em, input logic d);
    exp_t x;
    @(negedge clk);
    meta_valid = v; meta = m; stall_decode = s; flush = f;
    x = '{a, r, rem, fu, em, d};
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check($sformatf("v%0d.active", vec), 32'(win_active), 32'(x.a));
        check($sformatf("v%0d.region", vec), 32'(win_region), 32'(x.r));
        check($sformatf("v%0d.remaining", vec), 32'(win_remaining), 32'(x.rem));
        check($sformatf("v%0d.full", vec), 32'(fifo_full), 32'(x.f));
        check($sformatf("v%0d.empty", vec), 32'(fifo_empty), 32'(x.e));
        check($sformatf("v%0d.drop", vec), 32'(drop_pulse), 32'(x.d));
        vec++;
      end
    end
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;
    // single window: region 1, count 3
    cyc(1, 10'h043, 0, 0,  0, 0, 0, 0, 0, 0);
    cyc(0, 10'h000, 0, 0,  1, 1, 3, 0, 1, 0);
    cyc(0, 10'h000, 0, 0,  1, 1, 2, 0, 1, 0);
    cyc(0, 10'h000, 0, 0,  1, 1, 1, 0, 1, 0);
    cyc(0, 10'h000, 0, 0,  0, 0, 0, 0, 1, 0);
    // back-to-back: region 2 x2 then region 3 x1
    cyc(1, 10'h082, 0, 0,  0, 0, 0, 0, 0, 0);
    cyc(1, 10'h0C1, 0, 0,  1, 2, 2, 0, 0, 0);
    cyc(0, 10'h000, 0, 0,  1, 2, 1, 0, 0, 0);
    cyc(0, 10'h000, 0, 0,  1, 3, 1, 0, 1, 0);
    cyc(0, 10'h000, 0, 0,  0, 0, 0, 0, 1, 0);
    // stall mid-window of count 4; beats offered during stall are ignored
    cyc(1, 10'h104, 0, 0,  0, 0, 0, 0, 0, 0);
    cyc(0, 10'h000, 0, 0,  1, 4, 4, 0, 1, 0);
    cyc(0, 10'h000, 0, 0,  1, 4, 3, 0, 1, 0);
    cyc(1, 10'h0C5, 1, 0,  1, 4, 3, 0, 1, 0);
    cyc(1, 10'h0C5, 1, 0,  1, 4, 3, 0, 1, 0);
    cyc(0, 10'h000, 0, 0,  1, 4, 2, 0, 1, 0);
    cyc(0, 10'h000, 0, 0,  1, 4, 1, 0, 1, 0);
    cyc(0, 10'h000, 0, 0,  0, 0, 0, 0, 1, 0);
    // long window region 5 count 63, overfill FIFO, then flush with FIFO full
    cyc(1, 10'h17F, 0, 0,  0, 0, 0, 0, 0, 0);
    cyc(1, 10'h041, 0, 0,  1, 5, 63, 0, 0, 0);
    cyc(1, 10'h041, 0, 0,  1, 5, 62, 0, 0, 0);
    cyc(1, 10'h041, 0, 0,  1, 5, 61, 0, 0, 0);
    cyc(1, 10'h041, 0, 0,  1, 5, 60, 1, 0, 0);
    cyc(1, 10'h041, 0, 0,  1, 5, 59, 1, 0, 1);
    @(posedge clk);
    #2;
`ifdef NOP_META_DROP_CNT_EN
    check("drop_count_after_drop", 32'(drop_count), 1);
`endif
    cyc(0, 10'h000, 0, 0,  1, 5, 58, 1, 0, 0);
    cyc(1, 10'h041, 0, 1,  0, 0, 0, 0, 1, 0);
    cyc(0, 10'h000, 0, 0,  0, 0, 0, 0, 1, 0);
    // count-0 entry is popped and discarded
    cyc(1, 10'h140, 0, 0,  0, 0, 0, 0, 0, 0);
    cyc(0, 10'h000, 0, 0,  0, 0, 0, 0, 1, 0);
    cyc(0, 10'h000, 0, 0,  0, 0, 0, 0, 1, 0);
    // flush during an active window with two queued entries and a concurrent beat
    cyc(1, 10'h045, 0, 0,  0, 0, 0, 0, 0, 0);
    cyc(1, 10'h082, 0, 0,  1, 1, 5, 0, 0, 0);
    cyc(1, 10'h0C1, 0, 0,  1, 1, 4, 0, 0, 0);
    cyc(1, 10'h043, 0, 1,  0, 0, 0, 0, 1, 0);
    cyc(0, 10'h000, 0, 0,  0, 0, 0, 0, 1, 0);
`ifdef NOP_META_DROP_CNT_EN
    @(posedge clk);
    #2;
    check("drop_count_kept_by_flush", 32'(drop_count), 1);
`endif
    // async reset in the middle of a window
    cyc(1, 10'h107, 0, 0,  0, 0, 0, 0, 0, 0);
    cyc(0, 10'h000, 0, 0,  1, 4, 7, 0, 1, 0);
    cyc(0, 10'h000, 0, 0,  1, 4, 6, 0, 1, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    @(negedge clk);
    meta_valid = 1'b0; stall_decode = 1'b0; flush = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 10'h000, 0, 0,  0, 0, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
